// File: rtl/t_counter_pkg.sv
// Shared constants and helpers for the T-flip-flop modulo counter.
// Direction encodings and load clamping.
package t_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic logic [31:0] clamp_load(
        input logic [31:0] val,
        input logic [31:0] modulus
    );
        return (val >= modulus) ? (modulus - 32'd1) : val;
    endfunction

endpackage

// File: rtl/t_counter_ff_bit.sv
// Single T flip-flop, asynchronous active-low reset to 0.
// One instance per counter bit.
module t_ff_bit (
    input  logic clk,
    input  logic rstn,
    input  logic t,
    output logic q,
    output logic qn
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) q <= 1'b0;
        else       q <= q ^ t;
    end

    assign qn = ~q;

endmodule

// File: rtl/t_counter.sv
// Up/down modulo counter built from per-bit T flip-flops.
// Optional gray output enabled by defining T_COUNTER_GRAY_EN.
module t_counter
    import t_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2**WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
`ifdef T_COUNTER_GRAY_EN
    ,
    output logic [WIDTH-1:0] gray
`endif
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic [WIDTH-1:0] t_nat;
    logic [WIDTH-1:0] tgl;
    logic [WIDTH-1:0] clamped;
    logic             wrap_q;

    assign count   = q;
    assign clamped = WIDTH'(clamp_load(32'(load_val), 32'(MODULUS)));

    assign tc = en && !load &&
                (((up == DIR_UP) && (q == MAX)) ||
                 ((up == DIR_DOWN) && (q == '0)));

    // Natural binary toggle: bit i flips when all lower bits are 1 (up) or 0 (down)
    always_comb begin
        logic cu;
        logic cd;
        t_nat = '0;
        cu    = 1'b1;
        cd    = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t_nat[i] = (up == DIR_UP) ? cu : cd;
            cu       = cu & q[i];
            cd       = cd & qn[i];
        end
    end

    always_comb begin
        tgl = '0;
        if (load)
            tgl = q ^ clamped;
        else if (tc)
            tgl = q ^ ((up == DIR_UP) ? '0 : MAX);
        else if (en)
            tgl = t_nat;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        t_ff_bit u_ff (
            .clk  (clk),
            .rstn (rstn),
            .t    (tgl[i]),
            .q    (q[i]),
            .qn   (qn[i])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) wrap_q <= 1'b0;
        else       wrap_q <= tc;
    end

    assign wrap = wrap_q;

`ifdef T_COUNTER_GRAY_EN
    assign gray = q ^ (q >> 1);
`endif

endmodule
